// File: rtl/systolic_ctrl_pkg.sv
// Shared types and defaults for the systolic MAC array controller and array top.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  localparam int ARRAY_DIM_DEF = 4;
  localparam int KLEN_W_DEF    = 8;
  localparam int STALL_W_DEF   = 16;

  // Zeros needed to flush the skewed pipeline: skew + hops + load/mult/acc.
  function automatic int drain_len(input int dim);
    return 2 * dim;
  endfunction

endpackage

// File: rtl/systolic_mac_ctrl.sv
// Job sequencer for the systolic MAC array: clear, feed k_len beats, drain, done.
// Optional STALL_CNT_EN adds a saturating count of stalled FEED cycles.
//
// state | meaning
// IDLE  | waiting for start; k_len latched on start
// CLEAR | one-cycle clear pulse to every PE register
// FEED  | consume operand beats; array steps only on feed_vld
// DRAIN | inject zeros to flush the skewed pipeline
// DONE  | one-cycle done pulse, accumulators hold the tile
module systolic_mac_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int ARRAY_DIM = ARRAY_DIM_DEF,
  parameter int KLEN_W    = KLEN_W_DEF
`ifdef STALL_CNT_EN
  , parameter int STALL_W = STALL_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [KLEN_W-1:0] k_len,
  input  logic              feed_vld,
  output logic              feed_req,
  output logic              zero_feed,
  output logic              clear_acc,
  output logic              load_en,
  output logic              mult_en,
  output logic              acc_en,
  output logic              busy,
`ifdef STALL_CNT_EN
  output logic [STALL_W-1:0] stall_cycles,
`endif
  output logic              done
);

  localparam int DRAIN_N = drain_len(ARRAY_DIM);
  localparam int CNT_W   = (KLEN_W > $clog2(DRAIN_N)) ? KLEN_W : $clog2(DRAIN_N);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [KLEN_W-1:0] klen_q;
  logic              step;

  // Stalls must freeze every PE stage together, so all three enables share step.
  assign step    = (feed_req & feed_vld) | zero_feed;
  assign load_en = step;
  assign mult_en = step;
  assign acc_en  = step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      klen_q    <= '0;
      feed_req  <= 1'b0;
      zero_feed <= 1'b0;
      clear_acc <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef STALL_CNT_EN
      stall_cycles <= '0;
`endif
    end else begin
      clear_acc <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            klen_q    <= k_len;
            cnt       <= '0;
            clear_acc <= 1'b1;
            busy      <= 1'b1;
`ifdef STALL_CNT_EN
            stall_cycles <= '0;
`endif
          end
        end
        CLEAR: begin
          if (klen_q != '0) begin
            state    <= FEED;
            feed_req <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        FEED: begin
          if (feed_vld) begin
            if (cnt == CNT_W'(klen_q) - 1'b1) begin
              state     <= DRAIN;
              cnt       <= '0;
              feed_req  <= 1'b0;
              zero_feed <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef STALL_CNT_EN
          else if (stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (cnt == CNT_W'(DRAIN_N - 1)) begin
            state     <= DONE;
            cnt       <= '0;
            zero_feed <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          feed_req  <= 1'b0;
          zero_feed <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mac_ctrl.sv
// Directed bench for systolic_mac_ctrl with a small behavioural 4x4 PE array model.
// Build with STALL_CNT_EN defined to also check stall_cycles.
module tb_systolic_mac_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] k_len;
  logic       feed_vld;
  logic       feed_req, zero_feed, clear_acc, load_en, mult_en, acc_en, busy, done;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  systolic_mac_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .k_len     (k_len),
    .feed_vld  (feed_vld),
    .feed_req  (feed_req),
    .zero_feed (zero_feed),
    .clear_acc (clear_acc),
    .load_en   (load_en),
    .mult_en   (mult_en),
    .acc_en    (acc_en),
    .busy      (busy),
`ifdef STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .done      (done)
  );

  // Behavioural 4x4 array, DATAWIDTH 14, A and B edges all 3 and 5.
  logic [13:0] a_edge, b_edge;
  logic [13:0] sk_a [4][4];
  logic [13:0] sk_b [4][4];
  logic [13:0] row_in [4];
  logic [13:0] col_in [4];
  logic [13:0] a_r [4][4];
  logic [13:0] b_r [4][4];
  logic [13:0] m_r [4][4];
  logic [13:0] acc [4][4];

  assign a_edge = zero_feed ? 14'd0 : 14'd3;
  assign b_edge = zero_feed ? 14'd0 : 14'd5;

  always_comb begin
    row_in[0] = a_edge;
    col_in[0] = b_edge;
    for (int i = 1; i < 4; i++) begin
      row_in[i] = sk_a[i][i-1];
      col_in[i] = sk_b[i][i-1];
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset || clear_acc) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          sk_a[i][j] <= '0; sk_b[i][j] <= '0;
          a_r[i][j]  <= '0; b_r[i][j]  <= '0;
          m_r[i][j]  <= '0; acc[i][j]  <= '0;
        end
    end else if (load_en && mult_en && acc_en) begin
      for (int i = 0; i < 4; i++) begin
        sk_a[i][0] <= a_edge;
        sk_b[i][0] <= b_edge;
        for (int n = 1; n < 4; n++) begin
          sk_a[i][n] <= sk_a[i][n-1];
          sk_b[i][n] <= sk_b[i][n-1];
        end
      end
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          a_r[i][j] <= (j == 0) ? row_in[i] : a_r[i][j-1];
          b_r[i][j] <= (i == 0) ? col_in[j] : b_r[i-1][j];
          m_r[i][j] <= 14'(a_r[i][j] * b_r[i][j]);
          acc[i][j] <= acc[i][j] + m_r[i][j];
        end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one job starting at the current negedge; cycle 1 is the cycle after start.
  task automatic run_job(input int k, input int stall_after, input int stall_len,
                         input int restart_cyc,
                         output int clr_cyc, output int done_cyc, output int n_clr,
                         output int n_feed, output int n_zero, output int n_en,
                         output int n_split, output int n_busy);
    int beats   = 0;
    int stalled = 0;
    int cyc     = 0;
    clr_cyc = -1; done_cyc = -1; n_clr = 0;
    n_feed = 0; n_zero = 0; n_en = 0; n_split = 0; n_busy = 0;
    k_len    = 8'(k);
    start    = 1'b1;
    feed_vld = 1'b1;
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (clear_acc) begin
        n_clr++;
        if (clr_cyc < 0) clr_cyc = cyc;
      end
      if (done) done_cyc = cyc;
      if (feed_req)  n_feed++;
      if (zero_feed) n_zero++;
      if (busy)      n_busy++;
      if (load_en && mult_en && acc_en) n_en++;
      else if (load_en || mult_en || acc_en) n_split++;
      if (feed_req && feed_vld)  beats++;
      if (feed_req && !feed_vld) stalled++;
      start    = (cyc == restart_cyc);
      feed_vld = !(beats == stall_after && stalled < stall_len);
    end
    start    = 1'b0;
    feed_vld = 1'b1;
  endtask

  int clr_c, done_c, n_clr, n_feed, n_zero, n_en, n_split, n_busy, n_done;

  initial begin
    reset = 1'b1; start = 1'b1; k_len = 8'd3; feed_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_busy", busy, 0);
    end
    check("reset_outputs", {feed_req, zero_feed, clear_acc, load_en, mult_en, acc_en, busy, done}, 0);
`ifdef STALL_CNT_EN
    check("reset_stall", stall_cycles, 0);
`endif
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Plain job, k_len=3
    run_job(3, -1, 0, -1, clr_c, done_c, n_clr, n_feed, n_zero, n_en, n_split, n_busy);
    check("k3_clear_cyc", clr_c, 1);
    check("k3_feed_cycles", n_feed, 3);
    check("k3_zero_cycles", n_zero, 8);
    check("k3_done_cyc", done_c, 13);
    check("k3_en_cycles", n_en, 11);
    check("k3_en_split", n_split, 0);
    check("k3_busy_cycles", n_busy, 13);
`ifdef STALL_CNT_EN
    check("k3_stall", stall_cycles, 0);
`endif
    @(negedge clk);
    check("k3_idle_after", {busy, done}, 0);

    // Same job with a 2-cycle stall after beat 1
    run_job(3, 1, 2, -1, clr_c, done_c, n_clr, n_feed, n_zero, n_en, n_split, n_busy);
    check("stall_feed_cycles", n_feed, 5);
    check("stall_done_cyc", done_c, 15);
    check("stall_en_cycles", n_en, 11);
    check("stall_en_split", n_split, 0);
`ifdef STALL_CNT_EN
    check("stall_count", stall_cycles, 2);
    @(negedge clk);
    check("stall_count_hold", stall_cycles, 2);
`else
    @(negedge clk);
`endif

    // k_len = 0
    run_job(0, -1, 0, -1, clr_c, done_c, n_clr, n_feed, n_zero, n_en, n_split, n_busy);
    check("k0_clear_cyc", clr_c, 1);
    check("k0_done_cyc", done_c, 2);
    check("k0_en_cycles", n_en, 0);
    check("k0_busy_cycles", n_busy, 2);
    @(negedge clk);

    // start pulsed during FEED is ignored
    run_job(3, -1, 0, 3, clr_c, done_c, n_clr, n_feed, n_zero, n_en, n_split, n_busy);
    check("restart_clears", n_clr, 1);
    check("restart_done_cyc", done_c, 13);
    check("restart_en_cycles", n_en, 11);
    @(negedge clk);
    check("restart_idle_after", {busy, done, clear_acc}, 0);

    // Reset in FEED
    k_len = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midreset_in_feed", feed_req, 1);
    reset = 1'b1;
    #1;
    check("midreset_outputs", {feed_req, zero_feed, clear_acc, load_en, mult_en, acc_en, busy, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("midreset_no_done", n_done, 0);

    // Integrated array, k_len=4: 4 * 3 * 5 = 60 in every PE
    run_job(4, -1, 0, -1, clr_c, done_c, n_clr, n_feed, n_zero, n_en, n_split, n_busy);
    check("arr_done_cyc", done_c, 14);
    n_done = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (acc[i][j] !== 14'd60) n_done++;
    check("arr_acc_at_done", n_done, 0);
    check("arr_acc33_at_done", acc[3][3], 60);
    repeat (10) @(negedge clk);
    n_done = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (acc[i][j] !== 14'd60) n_done++;
    check("arr_acc_held", n_done, 0);
    check("arr_acc00_held", acc[0][0], 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
